// File: rtl/id_ex_issue_if.sv
// ID -> EX issue bus: decoded fields from the control unit, ALU flag writes from execute,
// pipeline control, and the registered ID/EX fields and status returned to the pipeline.
interface id_ex_issue_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [3:0]        exe_cmd_in;
   logic              mem_read_in, mem_write_in, wb_en_in, b_in, s_in;
   logic [3:0]        cond_in;
   logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
   logic              imm_in;
   logic [11:0]       shift_operand_in;
   logic [23:0]       signed_imm_24_in;
   logic [3:0]        dest_in;
   logic              hazard, flush, freeze;
   logic              status_we;
   logic [3:0]        status_nzcv_in;

   logic [3:0]        exe_cmd_out;
   logic              mem_read_out, mem_write_out, wb_en_out, b_out, s_out;
   logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
   logic              imm_out;
   logic [11:0]       shift_operand_out;
   logic [23:0]       signed_imm_24_out;
   logic [3:0]        dest_out;
   logic [3:0]        status_q;
   logic              carry_out;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, b_in, s_in, cond_in,
             pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
             dest_in, hazard, flush, freeze, status_we, status_nzcv_in,
      input  exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
             pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
             signed_imm_24_out, dest_out, status_q, carry_out, bubble_cnt
   );

   modport slave (
      input  exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, b_in, s_in, cond_in,
             pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
             dest_in, hazard, flush, freeze, status_we, status_nzcv_in,
      output exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
             pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
             signed_imm_24_out, dest_out, status_q, carry_out, bubble_cnt
   );
endinterface

// File: rtl/id_ex_issue_reg.sv
// ID/EX issue register: condition check against forwarded NZCV, bubble insertion,
// architectural status register and wrapping bubble counter.
module id_ex_issue_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst,
   id_ex_issue_if.slave  bus
);
   logic [3:0]        exe_cmd_q, exe_cmd_d;
   logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic              wb_en_q, wb_en_d, b_q, b_d, s_q, s_d;
   logic [DATA_W-1:0] pc_q, pc_d, val_rn_q, val_rn_d, val_rm_q, val_rm_d;
   logic              imm_q, imm_d;
   logic [11:0]       shift_operand_q, shift_operand_d;
   logic [23:0]       signed_imm_24_q, signed_imm_24_d;
   logic [3:0]        dest_q, dest_d;
   logic [3:0]        status_q, status_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic [3:0] nzcv_eff;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       cond_pass;
   logic       squash;

   // An instruction in ID must see the flags being written by the one in EX this cycle.
   assign nzcv_eff = bus.status_we ? bus.status_nzcv_in : status_q;
   assign {flag_n, flag_z, flag_c, flag_v} = nzcv_eff;

   always_comb begin
      cond_pass = 1'b0;
      case (bus.cond_in)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = !flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = !flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = !flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = !flag_v;
         4'b1000: cond_pass = flag_c && !flag_z;
         4'b1001: cond_pass = !flag_c || flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
         4'b1101: cond_pass = flag_z || (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign squash = bus.hazard || !cond_pass;

   always_comb begin
      exe_cmd_d       = exe_cmd_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      wb_en_d         = wb_en_q;
      b_d             = b_q;
      s_d             = s_q;
      pc_d            = pc_q;
      val_rn_d        = val_rn_q;
      val_rm_d        = val_rm_q;
      imm_d           = imm_q;
      shift_operand_d = shift_operand_q;
      signed_imm_24_d = signed_imm_24_q;
      dest_d          = dest_q;
      bubble_cnt_d    = bubble_cnt_q;
      // Status writes from EX land regardless of freeze/flush/hazard.
      status_d        = bus.status_we ? bus.status_nzcv_in : status_q;

      if (!bus.freeze) begin
         if (bus.flush) begin
            exe_cmd_d       = '0;
            mem_read_d      = 1'b0;
            mem_write_d     = 1'b0;
            wb_en_d         = 1'b0;
            b_d             = 1'b0;
            s_d             = 1'b0;
            pc_d            = '0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            imm_d           = 1'b0;
            shift_operand_d = '0;
            signed_imm_24_d = '0;
            dest_d          = '0;
            bubble_cnt_d    = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            pc_d            = bus.pc_in;
            val_rn_d        = bus.val_rn_in;
            val_rm_d        = bus.val_rm_in;
            imm_d           = bus.imm_in;
            shift_operand_d = bus.shift_operand_in;
            signed_imm_24_d = bus.signed_imm_24_in;
            dest_d          = bus.dest_in;
            if (squash) begin
               exe_cmd_d    = '0;
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               wb_en_d      = 1'b0;
               b_d          = 1'b0;
               s_d          = 1'b0;
               bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               exe_cmd_d    = bus.exe_cmd_in;
               mem_read_d   = bus.mem_read_in;
               mem_write_d  = bus.mem_write_in;
               wb_en_d      = bus.wb_en_in;
               b_d          = bus.b_in;
               s_d          = bus.s_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_cmd_q       <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         wb_en_q         <= 1'b0;
         b_q             <= 1'b0;
         s_q             <= 1'b0;
         pc_q            <= '0;
         val_rn_q        <= '0;
         val_rm_q        <= '0;
         imm_q           <= 1'b0;
         shift_operand_q <= '0;
         signed_imm_24_q <= '0;
         dest_q          <= '0;
         status_q        <= '0;
         bubble_cnt_q    <= '0;
      end else begin
         exe_cmd_q       <= exe_cmd_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         wb_en_q         <= wb_en_d;
         b_q             <= b_d;
         s_q             <= s_d;
         pc_q            <= pc_d;
         val_rn_q        <= val_rn_d;
         val_rm_q        <= val_rm_d;
         imm_q           <= imm_d;
         shift_operand_q <= shift_operand_d;
         signed_imm_24_q <= signed_imm_24_d;
         dest_q          <= dest_d;
         status_q        <= status_d;
         bubble_cnt_q    <= bubble_cnt_d;
      end
   end

   assign bus.exe_cmd_out       = exe_cmd_q;
   assign bus.mem_read_out      = mem_read_q;
   assign bus.mem_write_out     = mem_write_q;
   assign bus.wb_en_out         = wb_en_q;
   assign bus.b_out             = b_q;
   assign bus.s_out             = s_q;
   assign bus.pc_out            = pc_q;
   assign bus.val_rn_out        = val_rn_q;
   assign bus.val_rm_out        = val_rm_q;
   assign bus.imm_out           = imm_q;
   assign bus.shift_operand_out = shift_operand_q;
   assign bus.signed_imm_24_out = signed_imm_24_q;
   assign bus.dest_out          = dest_q;
   assign bus.status_q          = status_q;
   assign bus.carry_out         = status_q[1];
   assign bus.bubble_cnt        = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_issue_reg.sv
// Bench for id_ex_issue_reg: a reference model pushes the expected output record per edge,
// each scenario task pops it and compares against the sampled DUT outputs.
module tb_id_ex_issue_reg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic [3:0]        exe_cmd;
      logic              mem_read, mem_write, wb_en, b, s;
      logic [DATA_W-1:0] pc, rn, rm;
      logic              imm;
      logic [11:0]       shift;
      logic [23:0]       simm;
      logic [3:0]        dest;
      logic [3:0]        status;
      logic              carry;
      logic [CNT_W-1:0]  cnt;
   } out_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   out_t sb[$];
   out_t m;
   out_t got, exp;

   always #5 clk = ~clk;

   id_ex_issue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   id_ex_issue_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic b;
      case (c[3:1])
         3'd0: b = f[2];
         3'd1: b = f[1];
         3'd2: b = f[3];
         3'd3: b = f[0];
         3'd4: b = f[1] & ~f[2];
         3'd5: b = ~(f[3] ^ f[0]);
         3'd6: b = ~f[2] & ~(f[3] ^ f[0]);
         default: b = 1'b1;
      endcase
      return c[0] ? ~b : b;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.exe_cmd = bus.exe_cmd_out;   o.mem_read = bus.mem_read_out;
      o.mem_write = bus.mem_write_out; o.wb_en = bus.wb_en_out;
      o.b = bus.b_out;               o.s = bus.s_out;
      o.pc = bus.pc_out;             o.rn = bus.val_rn_out;   o.rm = bus.val_rm_out;
      o.imm = bus.imm_out;           o.shift = bus.shift_operand_out;
      o.simm = bus.signed_imm_24_out; o.dest = bus.dest_out;
      o.status = bus.status_q;       o.carry = bus.carry_out;  o.cnt = bus.bubble_cnt;
      return o;
   endfunction

   task automatic idle_inputs();
      bus.exe_cmd_in = 4'd0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.wb_en_in = 0;
      bus.b_in = 0; bus.s_in = 0; bus.cond_in = 4'b1110;
      bus.pc_in = '0; bus.val_rn_in = '0; bus.val_rm_in = '0; bus.imm_in = 0;
      bus.shift_operand_in = '0; bus.signed_imm_24_in = '0; bus.dest_in = '0;
      bus.hazard = 0; bus.flush = 0; bus.freeze = 0; bus.status_we = 0; bus.status_nzcv_in = '0;
   endtask

   // Model one edge from the currently driven inputs, push the expectation, then advance.
   task automatic step();
      logic [3:0] eff;
      logic       bubble;
      if (rst) begin
         m = '0;
      end else begin
         eff = bus.status_we ? bus.status_nzcv_in : m.status;
         if (!bus.freeze) begin
            if (bus.flush) begin
               m.exe_cmd = 0; m.mem_read = 0; m.mem_write = 0; m.wb_en = 0; m.b = 0; m.s = 0;
               m.pc = 0; m.rn = 0; m.rm = 0; m.imm = 0; m.shift = 0; m.simm = 0; m.dest = 0;
               m.cnt = m.cnt + 1'b1;
            end else begin
               bubble = bus.hazard | ~cond_ok(bus.cond_in, eff);
               m.pc = bus.pc_in; m.rn = bus.val_rn_in; m.rm = bus.val_rm_in; m.imm = bus.imm_in;
               m.shift = bus.shift_operand_in; m.simm = bus.signed_imm_24_in; m.dest = bus.dest_in;
               m.exe_cmd   = bubble ? 4'd0 : bus.exe_cmd_in;
               m.mem_read  = bubble ? 1'b0 : bus.mem_read_in;
               m.mem_write = bubble ? 1'b0 : bus.mem_write_in;
               m.wb_en     = bubble ? 1'b0 : bus.wb_en_in;
               m.b         = bubble ? 1'b0 : bus.b_in;
               m.s         = bubble ? 1'b0 : bus.s_in;
               if (bubble) m.cnt = m.cnt + 1'b1;
            end
         end
         if (bus.status_we) m.status = bus.status_nzcv_in;
      end
      m.carry = m.status[1];
      sb.push_back(m);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.exe_cmd_in = 4'hF; bus.mem_read_in = 1; bus.mem_write_in = 1; bus.wb_en_in = 1;
      bus.b_in = 1; bus.s_in = 1; bus.cond_in = 4'b1110; bus.pc_in = '1; bus.val_rn_in = '1;
      bus.val_rm_in = '1; bus.imm_in = 1; bus.shift_operand_in = '1; bus.signed_imm_24_in = '1;
      bus.dest_in = 4'hF; bus.hazard = 1; bus.flush = 1; bus.freeze = 1;
      bus.status_we = 1; bus.status_nzcv_in = 4'hF;
      rst = 1;
      step();
      rst = 0;
      idle_inputs();
      got = sample(); exp = sb.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_record got=%h exp=%h", got, exp); end
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_all_zero got=%h exp=0", got); end
   endtask

   task automatic test_cond_pass_fail();
      logic [CNT_W-1:0] cnt0;
      bus.status_we = 1; bus.status_nzcv_in = 4'b0100;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL status_write got=%h exp=%h", got, exp); end
      idle_inputs();
      bus.exe_cmd_in = 4'b0010; bus.wb_en_in = 1; bus.cond_in = 4'b0000; bus.dest_in = 4'd5;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.exe_cmd !== 4'b0010 || got.wb_en !== 1'b1) begin
         errors++; $display("FAIL cond_eq_pass got=%h exp=%h", got, exp);
      end
      cnt0 = got.cnt;
      bus.cond_in = 4'b0001; bus.dest_in = 4'd9;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.exe_cmd !== 0 || got.wb_en !== 0 || got.dest !== 4'd9
          || got.cnt !== cnt0 + 1'b1) begin
         errors++; $display("FAIL cond_ne_squash got=%h exp=%h", got, exp);
      end
      idle_inputs();
   endtask

   task automatic test_forwarding();
      bus.status_we = 1; bus.status_nzcv_in = 4'b0000;
      bus.cond_in = 4'b0000; bus.wb_en_in = 1; bus.exe_cmd_in = 4'd4;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.wb_en !== 1'b0 || got.status !== 4'b0000) begin
         errors++; $display("FAIL forward_squash got=%h exp=%h", got, exp);
      end
      idle_inputs();
      // Carry follows the register only: forwarded C=1 must not show on carry_out early.
      bus.status_we = 1; bus.status_nzcv_in = 4'b0010; bus.cond_in = 4'b0010; bus.wb_en_in = 1;
      #1; checks++;
      if (bus.carry_out !== 1'b0) begin
         errors++; $display("FAIL carry_not_forwarded got=%b exp=0", bus.carry_out);
      end
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.wb_en !== 1'b1 || got.carry !== 1'b1) begin
         errors++; $display("FAIL forward_pass got=%h exp=%h", got, exp);
      end
      idle_inputs();
   endtask

   task automatic test_hazard();
      bus.mem_write_in = 1; bus.exe_cmd_in = 4'b0010; bus.val_rm_in = 32'hCAFE_0123;
      bus.hazard = 1;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.mem_write !== 0 || got.rm !== 32'hCAFE_0123) begin
         errors++; $display("FAIL hazard_bubble got=%h exp=%h", got, exp);
      end
      bus.hazard = 0;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.mem_write !== 1'b1) begin
         errors++; $display("FAIL hazard_release got=%h exp=%h", got, exp);
      end
      idle_inputs();
   endtask

   task automatic test_freeze_flush();
      out_t held;
      bus.exe_cmd_in = 4'd3; bus.wb_en_in = 1; bus.pc_in = 32'h100; bus.dest_in = 4'd7;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL ff_load got=%h exp=%h", got, exp); end
      held = got;
      bus.freeze = 1; bus.flush = 1; bus.pc_in = 32'h200;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got !== held) begin
         errors++; $display("FAIL freeze_hold got=%h exp=%h", got, exp);
      end
      bus.freeze = 0; bus.hazard = 1;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.exe_cmd !== 0 || got.pc !== 0 || got.dest !== 0
          || got.cnt !== held.cnt + 1'b1) begin
         errors++; $display("FAIL flush_zero got=%h exp=%h", got, exp);
      end
      idle_inputs();
   endtask

   task automatic test_edges();
      for (int i = 0; i < 4; i++) begin
         bus.status_we = 1; bus.status_nzcv_in = 4'($urandom_range(0, 15));
         bus.cond_in = 4'b1111; bus.wb_en_in = 1; bus.b_in = 1;
         step(); got = sample(); exp = sb.pop_front(); checks++;
         if (got !== exp || got.wb_en !== 0 || got.b !== 0) begin
            errors++; $display("FAIL never_squash got=%h exp=%h", got, exp);
         end
      end
      bus.status_nzcv_in = 4'b1111; step(); void'(sb.pop_front());
      idle_inputs();
      bus.cond_in = 4'b1110; bus.s_in = 1; bus.exe_cmd_in = 4'd9;
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.s !== 1'b1 || got.exe_cmd !== 4'd9 || got.status !== 4'b1111) begin
         errors++; $display("FAIL always_issue got=%h exp=%h", got, exp);
      end
      idle_inputs();
      bus.cond_in = 4'b1111;
      for (int i = 0; i < 20 && m.cnt != {CNT_W{1'b1}}; i++) begin
         step(); got = sample(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL preload got=%h exp=%h", got, exp); end
      end
      checks++;
      if (bus.bubble_cnt !== {CNT_W{1'b1}}) begin
         errors++; $display("FAIL preload_max got=%0d exp=%0d", bus.bubble_cnt, {CNT_W{1'b1}});
      end
      step(); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp || got.cnt !== '0) begin
         errors++; $display("FAIL cnt_wrap got=%0d exp=0", got.cnt);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         bus.exe_cmd_in = 4'($urandom); bus.mem_read_in = 1'($urandom); bus.mem_write_in = 1'($urandom);
         bus.wb_en_in = 1'($urandom); bus.b_in = 1'($urandom); bus.s_in = 1'($urandom);
         bus.cond_in = 4'($urandom); bus.pc_in = $urandom; bus.val_rn_in = $urandom;
         bus.val_rm_in = $urandom; bus.imm_in = 1'($urandom); bus.shift_operand_in = 12'($urandom);
         bus.signed_imm_24_in = 24'($urandom); bus.dest_in = 4'($urandom);
         bus.hazard = ($urandom_range(0, 5) == 0); bus.flush = ($urandom_range(0, 7) == 0);
         bus.freeze = ($urandom_range(0, 7) == 0); bus.status_we = 1'($urandom);
         bus.status_nzcv_in = 4'($urandom);
         rst = ($urandom_range(0, 60) == 0);
         step(); got = sample();
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL random_empty_queue got=%h", got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin errors++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp); end
         end
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      m = '0;
      idle_inputs();
      @(posedge clk); #1;
      test_reset();
      test_cond_pass_fail();
      test_forwarding();
      test_hazard();
      test_freeze_flush();
      test_edges();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_issue_reg.md
# id_ex_issue_reg

Issue stage between instruction decode and execute. Evaluates the instruction's ARM-style condition field against the NZCV status register, with same-cycle forwarding of status writes from execute. Turns failed-condition, hazard-stalled and flushed instructions into bubbles. Registers the decoded control and operand fields into the ID/EX pipeline register. Also owns the architectural status register and a wrapping bubble counter.

## Interface
Parameters:
- DATA_W, 32, width of PC, register values and immediates
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- exe_cmd_in  in  4  ALU command from control unit
- mem_read_in, mem_write_in, wb_en_in, b_in, s_in  in  1 each  control bits from control unit
- cond_in  in  4  instruction condition field
- pc_in, val_rn_in, val_rm_in  in  DATA_W  PC and source operand values
- imm_in  in  1  immediate-operand flag
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  destination register number
- hazard  in  1  data-hazard stall; inject bubble
- flush  in  1  taken branch in EX; squash ID instruction
- freeze  in  1  global pipeline hold
- status_we  in  1  EX instruction has S set; write status
- status_nzcv_in  in  4  ALU flags {N,Z,C,V}
- All *_out  out  same widths as matching *_in  registered ID/EX fields
- status_q  out  4  current NZCV register
- carry_out  out  1  status_q[1] (C), combinational from register
- bubble_cnt  out  CNT_W  count of bubbles inserted

## Operation
- Effective flags: nzcv_eff = status_we ? status_nzcv_in : status_q (forwarding).
- Condition pass, by cond_in:
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 N
  - 0101 !N
  - 0110 V
  - 0111 !V
  - 1000 C&!Z
  - 1001 !C|Z
  - 1010 N==V
  - 1011 N!=V
  - 1100 !Z&(N==V)
  - 1101 Z|(N!=V)
  - 1110 always pass
  - 1111 never pass
- Status register: on each clock edge with status_we=1, status_q <= status_nzcv_in. This happens regardless of freeze, flush or hazard. Otherwise status_q holds.
- ID/EX register update priority, highest first:
  1. rst: all outputs 0, status_q=0000, bubble_cnt=0.
  2. freeze: all *_out hold; bubble_cnt holds.
  3. flush: all *_out <= 0, including data fields; bubble_cnt += 1.
  4. hazard=1 or condition fails:
     - exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out <= 0.
     - Data fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest) latched from inputs.
     - bubble_cnt += 1.
  5. Otherwise: all *_out <= corresponding *_in.
- bubble_cnt wraps modulo 2^CNT_W; no saturation.
- The block does no decoding of its own; exe_cmd and control bits pass through unchanged when issued.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on *_out after edge N.
- status_q reflects status_we/status_nzcv_in one cycle after the write edge.
- Forwarding makes an instruction in ID see the flags written by the instruction currently in EX in the same cycle.
- carry_out changes only with status_q, never with forwarded flags.
- Simultaneous flush and hazard: flush wins; all fields zeroed; counter +1 once.
- Simultaneous freeze and flush: outputs hold; flush is ignored that cycle. The upstream must hold flush until freeze drops.
- Reset mid-stream clears in-flight ID/EX contents and status on the same edge. The first post-reset instruction evaluates against status 0000.
- A bubble emits no write-back, memory access, branch or status write downstream.

## Test plan
- Reset: drive all inputs nonzero, rst=1 for one edge -> every output 0, status_q=0000, bubble_cnt=0.
- Condition pass and fail:
  - Write status 0100 (Z=1).
  - Next cycle issue ADD (exe_cmd_in=0010, wb_en_in=1, cond_in=0000) -> exe_cmd_out=0010, wb_en_out=1.
  - Then the same with cond_in=0001 -> exe_cmd_out=0, wb_en_out=0, dest_out latched, bubble_cnt +1.
- Forwarding:
  - status_q=0100; same cycle status_we=1, status_nzcv_in=0000; cond_in=0000 with wb_en_in=1 -> wb_en_out=0 (squashed).
  - Next cycle status_q=0000.
- Hazard: STR (mem_write_in=1, exe_cmd_in=0010, cond 1110) with hazard=1 -> mem_write_out=0, val_rm_out latched. Next cycle hazard=0 -> mem_write_out=1.
- Freeze/flush:
  - Valid instruction registered.
  - freeze=1, flush=1 -> outputs unchanged, bubble_cnt unchanged.
  - freeze=0, flush=1 -> all *_out=0, bubble_cnt +1.
- Edge conditions:
  - cond_in=1111 with any status -> squashed.
  - cond_in=1110 with status 1111 -> issued.
  - Preload bubble_cnt to 2^CNT_W-1 via repeated squashes (CNT_W=4 build), one more squash -> bubble_cnt=0.
